i2c_arbiter: RTL

//   Shares the single i2c master between NREQ requesters with round-robin

---
 rtl/i2c_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one i2c master between NREQ requesters using round-robin
//   arbitration. The winner's command (rw, mode, address, write data) is
//   latched at grant time and presented to the master unchanged until the
//   transfer finishes. The master's ready handshake is followed through
//   START (enable high, waiting for the master to go busy) and BUSY
//   (waiting for the master to return to idle). A saturating watchdog ends
//   a transfer that hangs in either phase. FINISH lasts one cycle and
//   carries the done pulse, the error flag and the read data.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req                 per-requester request level, held until done
//   req_rw, req_mode    per-requester read/write select and master mode bit
//   req_addr            per-requester 7-bit address, slot i at [7i+6:7i]
//   req_wdata           per-requester write data, slot i at [32i+31:32i]
//   gnt                 one-hot grant, held from START through FINISH
//   done, err, rdata    completion pulse, watchdog error, read data
//   i2c_enable          master enable, high only in START
//   i2c_rw, i2c_mode,
//   i2c_addr,
//   i2c_reg_read        latched command to the master
//   i2c_reg_write       data returned by the master on reads
//   i2c_ready           master idle (high) / busy (low)

module i2c_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 i2c_enable,
  output logic                 i2c_rw,
  output logic                 i2c_mode,
  output logic [6:0]           i2c_addr,
  output logic [31:0]          i2c_reg_read,
  input  logic [31:0]          i2c_reg_write,
  input  logic                 i2c_ready
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [15:0]      WDOG_LIMIT = 16'(TIMEOUT);
  localparam logic [15:0]      WDOG_MAX   = 16'hFFFF;
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_BUSY   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt_q;
  logic             rw_q;
  logic             mode_q;
  logic [6:0]       addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_flag;
  logic [15:0]      wdog;

  logic             wdog_expired;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [SUM_W-1:0] cand;

  assign wdog_expired = (wdog >= WDOG_LIMIT);

  // Round-robin pick: scan ptr, ptr+1, ... wrapping at NREQ; first set wins.
  // cand is one bit wider than ptr so the wrap can be detected before it is
  // folded back into range.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + SUM_W'(k);
      if (cand >= SUM_W'(NREQ)) begin
        cand = cand - SUM_W'(NREQ);
      end
      if (!pick_found && req[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. In START a busy master wins over an expiring watchdog,
  // and in BUSY a returning master wins, so a transfer that completes on the
  // last allowed cycle is not reported as an error.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_found && i2c_ready) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (!i2c_ready) begin
          state_nxt = S_BUSY;
        end else if (wdog_expired) begin
          state_nxt = S_FINISH;
        end
      end
      S_BUSY: begin
        if (i2c_ready || wdog_expired) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch, watchdog, result capture and priority rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_q    <= '0;
      rw_q     <= 1'b0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_flag <= 1'b0;
      wdog     <= '0;
    end else begin
      // The watchdog restarts on every state change and sticks at all-ones.
      if (state_nxt != state) begin
        wdog <= '0;
      end else if (wdog != WDOG_MAX) begin
        wdog <= wdog + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (state_nxt == S_START) begin
            gnt_q    <= NREQ'(1) << pick_idx;
            gnt_idx  <= pick_idx;
            rw_q     <= req_rw[pick_idx];
            mode_q   <= req_mode[pick_idx];
            addr_q   <= req_addr[7*int'(pick_idx) +: 7];
            wdata_q  <= req_wdata[32*int'(pick_idx) +: 32];
            err_flag <= 1'b0;
          end
        end
        S_START: begin
          if (state_nxt == S_FINISH) begin
            err_flag <= 1'b1;
            rdata_q  <= '0;
          end
        end
        S_BUSY: begin
          if (state_nxt == S_FINISH) begin
            if (i2c_ready) begin
              rdata_q <= rw_q ? i2c_reg_write : 32'd0;
            end else begin
              err_flag <= 1'b1;
              rdata_q  <= '0;
            end
          end
        end
        S_FINISH: begin
          gnt_q    <= '0;
          err_flag <= 1'b0;
          ptr      <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
        end
        default: begin
          gnt_q <= '0;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign done         = (state == S_FINISH) ? gnt_q : '0;
  assign err          = (state == S_FINISH) && err_flag;
  assign rdata        = (state == S_FINISH) ? rdata_q : 32'd0;
  assign i2c_enable   = (state == S_START);
  assign i2c_rw       = rw_q;
  assign i2c_mode     = mode_q;
  assign i2c_addr     = addr_q;
  assign i2c_reg_read = wdata_q;

endmodule
